// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and data accesses.
// One outstanding transaction; data has priority, with fetch anti-starvation.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_FETCH_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    input  logic [3:0]            dm_be,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    input  logic                  flush_f,
    output logic                  stall_f,
    output logic                  stall_m,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int FW_W = $clog2(MAX_FETCH_WAIT + 1);
    localparam logic [FW_W-1:0] FW_MAX = FW_W'(MAX_FETCH_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_DM,
        WAIT_IF,
        WAIT_DM
    } state_t;

    state_t state;
    state_t state_n;

    logic [FW_W-1:0]       fetch_wait;
    logic [FW_W-1:0]       fetch_wait_n;
    logic                  discard;
    logic                  discard_n;
    logic                  mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_n;
    logic [DATA_WIDTH-1:0] mem_wdata_n;
    logic [3:0]            mem_be_n;
    logic [DATA_WIDTH-1:0] if_rdata_n;
    logic [DATA_WIDTH-1:0] dm_rdata_n;
    logic                  if_valid_n;
    logic                  dm_valid_n;

    logic fetch_force;
    logic grant_dm;
    logic grant_if;
    logic fetch_busy;

    // Fetch wins over data only once it has been passed over long enough.
    assign fetch_force = if_req && !flush_f && (fetch_wait == FW_MAX);
    assign grant_dm    = (state == IDLE) && dm_req && !fetch_force;
    assign grant_if    = (state == IDLE) && if_req && !flush_f && !grant_dm;
    assign fetch_busy  = (state == REQ_IF) || (state == WAIT_IF);

    assign mem_req = (state == REQ_IF) || (state == REQ_DM);
    assign stall_f = if_req && !if_valid && !flush_f;
    assign stall_m = dm_req && !dm_valid;

    // Count cycles a pending fetch is kept waiting; a flush drops the claim.
    always_comb begin
        fetch_wait_n = fetch_wait;
        if (grant_if || flush_f) begin
            fetch_wait_n = '0;
        end else if (if_req && !fetch_busy && (fetch_wait != FW_MAX)) begin
            fetch_wait_n = fetch_wait + FW_W'(1);
        end
    end

    // Next-state, payload capture and response routing.
    always_comb begin
        state_n     = state;
        discard_n   = discard;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_be_n    = mem_be;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        if_valid_n  = 1'b0;
        dm_valid_n  = 1'b0;
        unique case (state)
            IDLE: begin
                discard_n = 1'b0;
                if (grant_dm) begin
                    state_n     = REQ_DM;
                    mem_we_n    = dm_we;
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    mem_be_n    = dm_we ? dm_be : 4'b1111;
                end else if (grant_if) begin
                    state_n     = REQ_IF;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = if_addr;
                    mem_wdata_n = '0;
                    mem_be_n    = 4'b1111;
                end
            end
            REQ_IF: begin
                if (mem_ready) begin
                    // Already accepted: the response must still be drained.
                    state_n = WAIT_IF;
                    if (flush_f) begin
                        discard_n = 1'b1;
                    end
                end else if (flush_f) begin
                    state_n = IDLE;
                end
            end
            REQ_DM: begin
                if (mem_ready) begin
                    state_n = WAIT_DM;
                end
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    state_n    = IDLE;
                    if_rdata_n = mem_rdata;
                    if_valid_n = !(discard || flush_f);
                    discard_n  = 1'b0;
                end else if (flush_f) begin
                    discard_n = 1'b1;
                end
            end
            WAIT_DM: begin
                if (mem_rvalid) begin
                    state_n    = IDLE;
                    dm_rdata_n = mem_rdata;
                    dm_valid_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fetch_wait <= '0;
            discard    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_wait <= fetch_wait_n;
            discard    <= discard_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_be     <= mem_be_n;
            if_rdata   <= if_rdata_n;
            dm_rdata   <= dm_rdata_n;
            if_valid   <= if_valid_n;
            dm_valid   <= dm_valid_n;
        end
    end

endmodule
